// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package regfile_pkg;

  // Default register address width (32 architectural registers).
  localparam int ADDR_W = 5;

  // Default register data width.
  localparam int DATA_W = 64;

  // Hard-wired zero register: writes to it are accepted but never reach the port.
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  // One writeback request as seen by the write port.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage : regfile_pkg

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin priority picker. The search starts at ptr and
// wraps modulo NREQ; the first set bit of valid wins. Reusable by any arbiter
// that keeps its own priority pointer.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W:0] pos_s;
  logic           found_s;

  // Walk the requesters from ptr upward, wrapping once, and take the first valid one.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    pos_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s = {1'b0, ptr} + (PTR_W+1)'(k);
      if (pos_s >= (PTR_W+1)'(NREQ)) begin
        pos_s = pos_s - (PTR_W+1)'(NREQ);
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && valid[pos_s[PTR_W-1:0]]) begin
        found_s                  = 1'b1;
        grant[pos_s[PTR_W-1:0]]  = 1'b1;
        idx                      = pos_s[PTR_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule : rr_pick

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: one round-robin grant per cycle among the
// writeback requesters, registered onto the single write port, with writes to
// the zero register accepted but suppressed.
module regfile_wr_arbiter
  import regfile_pkg::ZERO_REG;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         hold,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]  req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic                         busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [NREQ-1:0]   grant_s;
  logic [PTR_W-1:0]  idx_s;
  logic              transfer_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_data_s;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant_s),
    .idx   (idx_s)
  );

  // A grant is only real outside reset and stall; reset_n gates it so ready stays low in reset.
  assign transfer_s = (|grant_s) & ~hold & reset_n;
  assign req_ready  = transfer_s ? grant_s : '0;
  assign busy       = (|req_valid) & ~transfer_s;
  assign win_addr_s = req_addr[idx_s];
  assign win_data_s = req_data[idx_s];

  // Next pointer sits just past the winner; unchanged when nothing transfers.
  always_comb begin
    ptr_d = ptr_q;
    if (transfer_s) begin
      if (idx_s == PTR_W'(NREQ-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = idx_s + PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Zero-register filter: the handshake completes but the port stays disabled.
  always_comb begin
    wr_en_d = 1'b0;
    if (transfer_s && (win_addr_s != ADDR_W'(ZERO_REG))) begin
      wr_en_d = 1'b1;
    end else begin
      wr_en_d = 1'b0;
    end
  end

  // Pointer and write-port register; address/data keep their last value when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_en_q <= wr_en_d;
      if (transfer_s) begin
        wr_addr_q <= win_addr_s;
        wr_data_q <= win_data_s;
      end else begin
        wr_addr_q <= wr_addr_q;
        wr_data_q <= wr_data_q;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule : regfile_wr_arbiter

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: per-requester stimulus queues,
// a reference arbiter model that pushes expected port values to a scoreboard,
// and compares against the registered write port one edge later.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 4;

  typedef struct packed {
    logic    en;
    wr_req_t w;
  } exp_t;

  logic                        clk;
  logic                        reset_n;
  logic                        hold;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][DATA_W-1:0] req_data;
  logic [NREQ-1:0]             req_ready;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [DATA_W-1:0]           wr_data;
  logic                        busy;

  regfile_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_fail   = 0;
  wr_req_t rq [NREQ][$];
  exp_t    sb [$];
  int      ptr_m;
  wr_req_t last_m;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_req(input int r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_req_t t;
    t.addr = a;
    t.data = d;
    rq[r].push_back(t);
  endtask

  task automatic model_reset();
    ptr_m       = 0;
    last_m.addr = '0;
    last_m.data = '0;
    sb.delete();
  endtask

  // One clock of traffic: drive, check grant, predict, then compare the port.
  task automatic step(input logic h, output logic [NREQ-1:0] rdy, output logic [ADDR_W-1:0] addr_seen);
    int   win;
    logic xfer;
    exp_t e;
    @(negedge clk);
    hold = h;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (rq[i].size() != 0);
      if (rq[i].size() != 0) begin
        req_addr[i] = rq[i][0].addr;
        req_data[i] = rq[i][0].data;
      end
    end
    #1;
    win  = model_pick(req_valid, ptr_m);
    xfer = (win >= 0) && !h;
    rdy  = req_ready;
    check_eq("req_ready", 64'(req_ready), xfer ? 64'(1) << win : 64'd0);
    check_eq("busy", 64'(busy), 64'((|req_valid) & ~xfer));
    if (xfer) begin
      last_m = rq[win].pop_front();
      e.en   = (last_m.addr != ZERO_REG);
      ptr_m  = (win + 1) % NREQ;
    end else begin
      e.en = 1'b0;
    end
    e.w = last_m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    addr_seen = wr_addr;
    check_eq("wr_en", 64'(wr_en), 64'(e.en));
    check_eq("wr_addr", 64'(wr_addr), 64'(e.w.addr));
    check_eq("wr_data", wr_data, e.w.data);
  endtask

  task automatic drain();
    logic [NREQ-1:0]   r;
    logic [ADDR_W-1:0] a;
    for (int g = 0; g < 64 && any_pending(); g++) step(1'b0, r, a);
    check_eq("drain_done", 64'(any_pending()), 64'd0);
  endtask

  logic [NREQ-1:0]   rdy_v;
  logic [ADDR_W-1:0] addr_v;
  logic [NREQ-1:0]   rr_exp_rdy [5];
  logic [ADDR_W-1:0] rr_exp_addr [5];

  initial begin
    rr_exp_rdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_exp_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1};
    reset_n   = 1'b0;
    hold      = 1'b0;
    req_valid = '1;
    req_addr  = '0;
    req_data  = '0;
    model_reset();

    // Reset with every requester asserting.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    check_eq("rst_wr_en", 64'(wr_en), 64'd0);
    check_eq("rst_wr_addr", 64'(wr_addr), 64'd0);
    check_eq("rst_wr_data", wr_data, 64'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = '0;

    // Round-robin with all four continuously valid.
    for (int r = 0; r < NREQ; r++) begin
      push_req(r, ADDR_W'(r + 1), 64'hA + 64'(r));
      push_req(r, ADDR_W'(r + 1), 64'hA + 64'(r));
    end
    for (int c = 0; c < 5; c++) begin
      step(1'b0, rdy_v, addr_v);
      check_eq("rr_grant", 64'(rdy_v), 64'(rr_exp_rdy[c]));
      check_eq("rr_addr", 64'(addr_v), 64'(rr_exp_addr[c]));
    end
    drain();

    // Zero-register write from requester 2 alone.
    push_req(2, 5'd31, 64'hFFFF);
    step(1'b0, rdy_v, addr_v);
    check_eq("zero_grant", 64'(rdy_v), 64'(4'b0100));
    check_eq("zero_wr_en", 64'(wr_en), 64'd0);
    check_eq("zero_ptr", 64'(dut.ptr_q), 64'd3);

    // Move the pointer back to 0, then stall requesters 1 and 3.
    push_req(3, 5'd12, 64'h33);
    drain();
    push_req(1, 5'd9, 64'h91);
    push_req(3, 5'd10, 64'hA3);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, rdy_v, addr_v);
      check_eq("hold_ready", 64'(rdy_v), 64'd0);
      check_eq("hold_wr_en", 64'(wr_en), 64'd0);
    end
    step(1'b0, rdy_v, addr_v);
    check_eq("hold_first", 64'(rdy_v), 64'(4'b0010));
    step(1'b0, rdy_v, addr_v);
    check_eq("hold_second", 64'(rdy_v), 64'(4'b1000));

    // Collision on r7 from requesters 0 and 1, pointer at 0.
    check_eq("coll_ptr0", 64'(dut.ptr_q), 64'd0);
    push_req(0, 5'd7, 64'h11);
    push_req(1, 5'd7, 64'h22);
    step(1'b0, rdy_v, addr_v);
    check_eq("coll_first", wr_data, 64'h11);
    step(1'b0, rdy_v, addr_v);
    check_eq("coll_second", wr_data, 64'h22);

    // Reset right after an accepted write.
    push_req(0, 5'd5, 64'h55);
    step(1'b0, rdy_v, addr_v);
    check_eq("mid_wr_en_pre", 64'(wr_en), 64'd1);
    @(negedge clk);
    req_valid = '1;
    reset_n   = 1'b0;
    #1;
    model_reset();
    check_eq("mid_wr_en", 64'(wr_en), 64'd0);
    check_eq("mid_wr_addr", 64'(wr_addr), 64'd0);
    check_eq("mid_wr_data", wr_data, 64'd0);
    check_eq("mid_ready", 64'(req_ready), 64'd0);
    check_eq("mid_ptr", 64'(dut.ptr_q), 64'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = '0;
    for (int r = 0; r < NREQ; r++) push_req(r, ADDR_W'(r + 20), 64'h100 + 64'(r));
    step(1'b0, rdy_v, addr_v);
    check_eq("post_rst_first", 64'(rdy_v), 64'(4'b0001));
    drain();

    // Random traffic with random stalls, zero register included.
    for (int c = 0; c < 80; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (rq[r].size() == 0 && $urandom_range(0, 1) == 1)
          push_req(r, ADDR_W'($urandom_range(0, 31)), {32'($urandom), 32'($urandom)});
      end
      step($urandom_range(0, 3) == 0, rdy_v, addr_v);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_wr_arbiter
